// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM loader bridge.
package wb_sram_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StRd,
      StRdw,
      StReg,
      StDeny,
      StAck
   } state_e;

   localparam logic [1:0]  REG_CTRL   = 2'd0;
   localparam logic [1:0]  REG_STATUS = 2'd1;
   localparam logic [1:0]  REG_CYCLES = 2'd2;

   localparam logic [31:0] DENY_DATA  = 32'hBADC_0DE5;

endpackage

// File: rtl/wb_sram_bridge_if.sv
// Wishbone classic slave bus between the management SoC and the SRAM bridge.
interface wb_sram_bridge_if;

   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_sram_decode.sv
// Combinational split of a Wishbone byte address into memory bank/word or register index.
module wb_sram_decode #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned NUM_BANKS = 2,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic [31:0]                  i_adr,
   output logic                         o_hit,
   output logic                         o_is_reg,
   output logic [$clog2(NUM_BANKS)-1:0] o_bank,
   output logic [ADDR_W-1:0]            o_word,
   output logic [1:0]                   o_reg_idx
);

   localparam int unsigned BANK_W   = $clog2(NUM_BANKS);
   localparam int unsigned REGION_W = ADDR_W + BANK_W + 3;

   logic [31:0] w_off;

   // Addresses below the base wrap to a huge offset and fall outside the region.
   assign w_off     = i_adr - BASE_ADDR;
   assign o_hit     = ((w_off >> REGION_W) == 32'd0);
   assign o_is_reg  = w_off[REGION_W-1];
   assign o_bank    = w_off[ADDR_W+2 +: BANK_W];
   assign o_word    = w_off[2 +: ADDR_W];
   assign o_reg_idx = w_off[3:2];

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone loader/readback bridge for NUM_BANKS SRAM macros plus core-reset control.
// Optional macro WB_CYCLE_COUNTER_EN adds the read-only CYCLES register.
module wb_sram_bridge
   import wb_sram_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned NUM_BANKS = 2,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   wb_sram_bridge_if.slave               wbs,
   output logic [NUM_BANKS-1:0]          sram_csb0,
   output logic                          sram_web0,
   output logic [3:0]                    sram_wmask0,
   output logic [ADDR_W-1:0]             sram_addr0,
   output logic [DATA_W-1:0]             sram_din0,
   input  logic [NUM_BANKS-1:0]          core_csb1,
   input  logic [NUM_BANKS*ADDR_W-1:0]   core_addr1,
   output logic [NUM_BANKS-1:0]          sram_csb1,
   output logic [NUM_BANKS*ADDR_W-1:0]   sram_addr1,
   input  logic [NUM_BANKS*DATA_W-1:0]   sram_dout1,
   output logic                          processor_reset
);

   localparam int unsigned          BANK_W   = $clog2(NUM_BANKS);
   localparam logic [NUM_BANKS-1:0] BANK_ONE = {{(NUM_BANKS-1){1'b0}}, 1'b1};
   localparam logic [1:0]           LAT_LAST = 2'(READ_LAT - 1);

   logic                        w_hit;
   logic                        w_is_reg;
   logic [BANK_W-1:0]           w_bank;
   logic [ADDR_W-1:0]           w_word;
   logic [1:0]                  w_reg_idx;
   logic [DATA_W-1:0]           w_reg_rdata;
   logic [DATA_W-1:0]           w_bank_dout;
   logic [31:0]                 w_cycles;

   state_e                      r_state;
   logic                        r_we;
   logic                        r_wsel0;
   logic                        r_wbit0;
   logic [BANK_W-1:0]           r_bank;
   logic [1:0]                  r_reg_idx;
   logic [1:0]                  r_lat_cnt;
   logic [NUM_BANKS-1:0]        r_csb0;
   logic                        r_web0;
   logic [3:0]                  r_wmask0;
   logic [ADDR_W-1:0]           r_addr0;
   logic [DATA_W-1:0]           r_din0;
   logic [NUM_BANKS-1:0]        r_csb1;
   logic [NUM_BANKS*ADDR_W-1:0] r_addr1;
   logic                        r_ack;
   logic [DATA_W-1:0]           r_dat;
   logic                        r_proc_rst;
   logic                        r_denied;

   wb_sram_decode #(
      .ADDR_W    (ADDR_W),
      .NUM_BANKS (NUM_BANKS),
      .BASE_ADDR (BASE_ADDR)
   ) u_decode (
      .i_adr     (wbs.wbs_adr_i),
      .o_hit     (w_hit),
      .o_is_reg  (w_is_reg),
      .o_bank    (w_bank),
      .o_word    (w_word),
      .o_reg_idx (w_reg_idx)
   );

`ifdef WB_CYCLE_COUNTER_EN
   logic [31:0] r_cycles;

   // Held at zero while the core is in reset, so each release restarts the count.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || r_proc_rst) r_cycles <= '0;
      else                        r_cycles <= r_cycles + 32'd1;
   end
   assign w_cycles = r_cycles;
`else
   assign w_cycles = '0;
`endif

   assign w_bank_dout = sram_dout1[r_bank*DATA_W +: DATA_W];

   always_comb begin
      w_reg_rdata = '0;
      case (r_reg_idx)
         REG_CTRL:   w_reg_rdata[0]   = r_proc_rst;
         REG_STATUS: w_reg_rdata[1:0] = {r_proc_rst, r_denied};
         REG_CYCLES: w_reg_rdata      = w_cycles;
         default:    w_reg_rdata      = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state    <= StIdle;
         r_we       <= 1'b0;
         r_wsel0    <= 1'b0;
         r_wbit0    <= 1'b0;
         r_bank     <= '0;
         r_reg_idx  <= '0;
         r_lat_cnt  <= '0;
         r_csb0     <= '1;
         r_web0     <= 1'b1;
         r_wmask0   <= '0;
         r_addr0    <= '0;
         r_din0     <= '0;
         r_csb1     <= '1;
         r_addr1    <= '0;
         r_ack      <= 1'b0;
         r_dat      <= '0;
         r_proc_rst <= 1'b1;
         r_denied   <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (wbs.wbs_stb_i && wbs.wbs_cyc_i && w_hit) begin
                  r_we      <= wbs.wbs_we_i;
                  r_wsel0   <= wbs.wbs_sel_i[0];
                  r_wbit0   <= wbs.wbs_dat_i[0];
                  r_bank    <= w_bank;
                  r_reg_idx <= w_reg_idx;
                  if (w_is_reg) begin
                     r_state <= StReg;
                  end else if (!r_proc_rst) begin
                     r_state <= StDeny;
                  end else if (wbs.wbs_we_i) begin
                     r_csb0   <= ~(BANK_ONE << w_bank);
                     r_web0   <= 1'b0;
                     r_wmask0 <= wbs.wbs_sel_i;
                     r_addr0  <= w_word;
                     r_din0   <= wbs.wbs_dat_i;
                     r_state  <= StWr;
                  end else begin
                     r_csb1  <= ~(BANK_ONE << w_bank);
                     r_addr1 <= {NUM_BANKS{w_word}};
                     r_state <= StRd;
                  end
               end
            end
            StWr: begin
               r_csb0   <= '1;
               r_web0   <= 1'b1;
               r_wmask0 <= '0;
               r_dat    <= '0;
               r_ack    <= 1'b1;
               r_state  <= StAck;
            end
            StRd: begin
               r_csb1    <= '1;
               r_lat_cnt <= '0;
               r_state   <= StRdw;
            end
            StRdw: begin
               if (r_lat_cnt == LAT_LAST) begin
                  r_dat   <= w_bank_dout;
                  r_ack   <= 1'b1;
                  r_state <= StAck;
               end else begin
                  r_lat_cnt <= r_lat_cnt + 2'd1;
               end
            end
            StReg: begin
               if (r_we && r_wsel0) begin
                  if (r_reg_idx == REG_CTRL) r_proc_rst <= r_wbit0;
                  if (r_reg_idx == REG_STATUS && r_wbit0) r_denied <= 1'b0;
               end
               r_dat   <= r_we ? '0 : w_reg_rdata;
               r_ack   <= 1'b1;
               r_state <= StAck;
            end
            StDeny: begin
               r_denied <= 1'b1;
               r_dat    <= r_we ? '0 : DENY_DATA;
               r_ack    <= 1'b1;
               r_state  <= StAck;
            end
            StAck: begin
               r_ack   <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign wbs.wbs_ack_o   = r_ack;
   assign wbs.wbs_dat_o   = r_dat;
   assign sram_csb0       = r_csb0;
   assign sram_web0       = r_web0;
   assign sram_wmask0     = r_wmask0;
   assign sram_addr0      = r_addr0;
   assign sram_din0       = r_din0;
   assign processor_reset = r_proc_rst;

   // Port 1 belongs to the core whenever it is out of reset.
   assign sram_csb1  = r_proc_rst ? r_csb1  : core_csb1;
   assign sram_addr1 = r_proc_rst ? r_addr1 : core_addr1;

endmodule
